vga_raster_driver: RTL and testbench
====================================

// Module: vga_raster_driver
// PURPOSE
//  Raster timing and pixel output stage for the game's VGA display. Generates pixel-tick
//  timing and the X/Y scan position for the scene-drawing logic, accepts its 10-bit
//  colour back, and emits aligned 8-bit RGB, HS, VS, BLANK_N and VGA_CLK pins.
//  Replaces the external VGA controller and its hand-made half-rate clock.
// PARAMETERS
//  CLK_DIV   2    system clocks per pixel (>=2)
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   horizontal sync width, pixels
//  H_BP      48   horizontal back porch, pixels
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vertical sync width, lines
//  V_BP      33   vertical back porch, lines
//  HS_POL    0    asserted level of vga_hs
//  VS_POL    0    asserted level of vga_vs
// PORTS
//  clk          in   1   system clock; sole clock of the block
//  rst          in   1   synchronous reset, active high
//  i_red        in   10  pixel colour from scene logic for (cur_x,cur_y); bits [9:2] used
//  i_green      in   10  as i_red
//  i_blue       in   10  as i_red
//  cur_x        out  11  column being requested; 0 outside active region
//  cur_y        out  11  line being requested; 0 outside active lines
//  request      out  1   high while (cur_x,cur_y) is a visible pixel
//  frame_start  out  1   one-clk pulse when the counters wrap to (0,0)
//  vga_r/g/b    out  8   registered colour pins
//  vga_hs       out  1   horizontal sync
//  vga_vs       out  1   vertical sync
//  vga_blank_n  out  1   low during blanking
//  vga_clk      out  1   pixel clock to the DAC
// BEHAVIOUR
//  - Divider div counts 0..CLK_DIV-1 and wraps. tick = (div==CLK_DIV-1).
//    vga_clk = (div >= CLK_DIV/2).
//  - Stage 0 counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) advance only on tick.
//    H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525).
//    h wraps to 0 and increments v. v wraps to 0 when h and v are both at their last values.
//  - Line order: active, front porch, sync, back porch (same for vertical).
//  - request = (h<H_ACTIVE)&&(v<V_ACTIVE), combinational from the counters.
//    cur_x = request ? h : 0. cur_y = (v<V_ACTIVE) ? v : 0.
//  - The scene logic has CLK_DIV-1 clks from a counter change to present stable colour.
//  - Stage 1 (registered, updates only on tick, uses pre-advance counter values):
//    - vga_r <= request ? i_red[9:2] : 0 (same for g and b)
//    - vga_blank_n <= request
//    - vga_hs <= HS_POL when h is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else ~HS_POL
//    - vga_vs <= VS_POL when v is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], else ~VS_POL
//    Pins therefore lag the counters by exactly 1 pixel period. Sync and colour stay aligned.
//  - frame_start is high for the one clk after the tick in which (h,v) wraps to (0,0).
//  - Reset values: div=0, h=0, v=0, vga_r/g/b=0, vga_blank_n=0, vga_hs=~HS_POL,
//    vga_vs=~VS_POL, frame_start=0, vga_clk=0.
//    After reset request=1, cur_x=0, cur_y=0.
//  - Reset mid-frame: all state returns to reset values on the next clk. No frame_start pulse.
//    The raster restarts at (0,0).
//  - Widths: counters are 11 bits. Parameter sums must stay below 2048.
// TESTING
//  1 Release rst, run 2 frames -> frame_start period = 800*525*2 = 840000 clk.
//    Pins hold reset values until the first tick.
//  2 HSYNC: vga_hs low for exactly 96 ticks (192 clk).
//    Its falling edge comes 657 ticks after the stage-0 line start (656 + 1 pipeline).
//  3 i_red=10'h3FC only when cur_x==100 && cur_y==50 -> vga_r=8'hFF for exactly one
//    pixel period, one tick later, with vga_blank_n=1.
//  4 i_red/g/b held at 10'h3FF -> RGB 0 whenever vga_blank_n=0.
//    Exactly 640 blank_n ticks per line and 480 lines per frame with blank_n.
//  5 Assert rst for 1 clk at v=200 -> next clk shows reset pin values.
//    The next frame_start arrives 840000 clk after rst falls.
//  6 Small raster (H 8/1/2/1, V 4/1/1/1, CLK_DIV=3) -> check wrap points,
//    vga_clk duty (1 low, 2 high) and HS/VS positions clock by clock.

Source files
------------

// File: rtl/vga_raster_driver.sv
// VGA raster timing generator with a one-pixel registered output stage.
// Counters drive the scene-logic request; colour and sync pins follow one pixel later.
module vga_raster_driver #(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  i_red,
   input  logic [9:0]  i_green,
   input  logic [9:0]  i_blue,
   output logic [10:0] cur_x,
   output logic [10:0] cur_y,
   output logic        request,
   output logic        frame_start,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic        vga_clk
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HsStart = H_ACTIVE + H_FP;
   localparam int unsigned VsStart = V_ACTIVE + V_FP;
   localparam int unsigned DivW    = $clog2(CLK_DIV);

   logic [DivW-1:0] div_q, div_d;
   logic [10:0]     h_q, h_d, v_q, v_d;
   logic [7:0]      r_q, r_d, g_q, g_d, b_q, b_d;
   logic            hs_q, hs_d, vs_q, vs_d, bn_q, bn_d, fs_q, fs_d, vclk_q, vclk_d;
   logic            tick, h_last, v_last, v_act, req, hs_on, vs_on;
   logic            unused_lsbs;

   // Only the top 8 colour bits reach the DAC.
   assign unused_lsbs = ^{i_red[1:0], i_green[1:0], i_blue[1:0]};

   always_comb begin
      tick   = (div_q == DivW'(CLK_DIV - 1));
      h_last = (h_q == 11'(H_TOTAL - 1));
      v_last = (v_q == 11'(V_TOTAL - 1));
      v_act  = (v_q < 11'(V_ACTIVE));
      req    = (h_q < 11'(H_ACTIVE)) && v_act;
      hs_on  = (h_q >= 11'(HsStart)) && (h_q < 11'(HsStart + H_SYNC));
      vs_on  = (v_q >= 11'(VsStart)) && (v_q < 11'(VsStart + V_SYNC));

      div_d  = tick ? '0 : div_q + 1'b1;
      vclk_d = (32'(div_d) >= (CLK_DIV / 2));
      fs_d   = tick && h_last && v_last;
      h_d    = h_q;
      v_d    = v_q;
      r_d    = r_q;
      g_d    = g_q;
      b_d    = b_q;
      bn_d   = bn_q;
      hs_d   = hs_q;
      vs_d   = vs_q;

      if (tick) begin
         if (h_last) begin
            h_d = '0;
            v_d = v_last ? '0 : v_q + 11'd1;
         end else begin
            h_d = h_q + 11'd1;
         end
         // Stage 1 samples the pre-advance position so pins trail counters by one pixel.
         r_d  = req ? i_red[9:2]   : 8'd0;
         g_d  = req ? i_green[9:2] : 8'd0;
         b_d  = req ? i_blue[9:2]  : 8'd0;
         bn_d = req;
         hs_d = hs_on ? HS_POL : ~HS_POL;
         vs_d = vs_on ? VS_POL : ~VS_POL;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q  <= '0;
         h_q    <= '0;
         v_q    <= '0;
         r_q    <= '0;
         g_q    <= '0;
         b_q    <= '0;
         bn_q   <= 1'b0;
         hs_q   <= ~HS_POL;
         vs_q   <= ~VS_POL;
         fs_q   <= 1'b0;
         vclk_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         h_q    <= h_d;
         v_q    <= v_d;
         r_q    <= r_d;
         g_q    <= g_d;
         b_q    <= b_d;
         bn_q   <= bn_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         fs_q   <= fs_d;
         vclk_q <= vclk_d;
      end
   end

   assign request     = req;
   assign cur_x       = req ? h_q : 11'd0;
   assign cur_y       = v_act ? v_q : 11'd0;
   assign frame_start = fs_q;
   assign vga_r       = r_q;
   assign vga_g       = g_q;
   assign vga_b       = b_q;
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign vga_blank_n = bn_q;
   assign vga_clk     = vclk_q;

endmodule

// File: tb/tb_vga_raster_driver.sv
// Bench for vga_raster_driver: two small rasters checked each clock against an
// elapsed-clock model, with random colours and random reset pulses.
module tb_vga_raster_driver;

   typedef struct packed {
      logic        req;
      logic [10:0] x;
      logic [10:0] y;
      logic        fs;
      logic [7:0]  r;
      logic [7:0]  g;
      logic [7:0]  b;
      logic        hs;
      logic        vs;
      logic        bn;
      logic        vc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [9:0] col_tbl [256];
   int unsigned n = 0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   logic [9:0]  a_ri, a_gi, a_bi, b_ri, b_gi, b_bi;
   logic [10:0] a_x, a_y, b_x, b_y;
   logic        a_req, a_fs, a_hs, a_vs, a_bn, a_vc;
   logic        b_req, b_fs, b_hs, b_vs, b_bn, b_vc;
   logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b;

   // Scene logic: colour is a pure function of the requested position.
   assign a_ri = col_tbl[{a_y[3:0], a_x[3:0]}];
   assign a_gi = col_tbl[{a_y[3:0], a_x[3:0]} ^ 8'h55];
   assign a_bi = col_tbl[{a_y[3:0], a_x[3:0]} ^ 8'hAA];
   assign b_ri = col_tbl[{b_y[3:0], b_x[3:0]}];
   assign b_gi = col_tbl[{b_y[3:0], b_x[3:0]} ^ 8'h55];
   assign b_bi = col_tbl[{b_y[3:0], b_x[3:0]} ^ 8'hAA];

   vga_raster_driver #(
      .CLK_DIV(3), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)
   ) u_a (
      .clk(clk), .rst(rst), .i_red(a_ri), .i_green(a_gi), .i_blue(a_bi),
      .cur_x(a_x), .cur_y(a_y), .request(a_req), .frame_start(a_fs),
      .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .vga_hs(a_hs), .vga_vs(a_vs),
      .vga_blank_n(a_bn), .vga_clk(a_vc)
   );

   vga_raster_driver #(
      .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .HS_POL(1'b1), .VS_POL(1'b1)
   ) u_b (
      .clk(clk), .rst(rst), .i_red(b_ri), .i_green(b_gi), .i_blue(b_bi),
      .cur_x(b_x), .cur_y(b_y), .request(b_req), .frame_start(b_fs),
      .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .vga_hs(b_hs), .vga_vs(b_vs),
      .vga_blank_n(b_bn), .vga_clk(b_vc)
   );

   // Expected outputs after n clocks out of reset, from raster arithmetic alone.
   function automatic exp_t model(int unsigned cnt, int unsigned cd,
                                  int unsigned ha, int unsigned hf, int unsigned hsw,
                                  int unsigned hb, int unsigned va, int unsigned vf,
                                  int unsigned vsw, int unsigned vb, bit hp, bit vp);
      exp_t e;
      int unsigned ht, vt, d, p, h, v, q, qh, qv, idx;
      ht = ha + hf + hsw + hb;
      vt = va + vf + vsw + vb;
      d  = cnt % cd;
      p  = cnt / cd;
      h  = p % ht;
      v  = (p / ht) % vt;
      e.req = (h < ha) && (v < va);
      e.x   = e.req ? 11'(h) : 11'd0;
      e.y   = (v < va) ? 11'(v) : 11'd0;
      e.vc  = (d >= cd / 2);
      e.fs  = (p > 0) && (d == 0) && (p % (ht * vt) == 0);
      if (p == 0) begin
         e.r = 8'd0; e.g = 8'd0; e.b = 8'd0; e.bn = 1'b0; e.hs = ~hp; e.vs = ~vp;
      end else begin
         q   = p - 1;
         qh  = q % ht;
         qv  = (q / ht) % vt;
         idx = (qv % 16) * 16 + (qh % 16);
         e.bn = (qh < ha) && (qv < va);
         e.r  = e.bn ? col_tbl[idx][9:2] : 8'd0;
         e.g  = e.bn ? col_tbl[idx ^ 'h55][9:2] : 8'd0;
         e.b  = e.bn ? col_tbl[idx ^ 'hAA][9:2] : 8'd0;
         e.hs = (qh >= ha + hf && qh < ha + hf + hsw) ? hp : ~hp;
         e.vs = (qv >= va + vf && qv < va + vf + vsw) ? vp : ~vp;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (n=%0d)", tag, obs, expv, n);
      end
   endtask

   task automatic check_inst(input string nm, input exp_t o, input exp_t e);
      chk({nm, "_request"}, 32'(o.req), 32'(e.req));
      chk({nm, "_cur_x"}, 32'(o.x), 32'(e.x));
      chk({nm, "_cur_y"}, 32'(o.y), 32'(e.y));
      chk({nm, "_frame_start"}, 32'(o.fs), 32'(e.fs));
      chk({nm, "_vga_r"}, 32'(o.r), 32'(e.r));
      chk({nm, "_vga_g"}, 32'(o.g), 32'(e.g));
      chk({nm, "_vga_b"}, 32'(o.b), 32'(e.b));
      chk({nm, "_vga_hs"}, 32'(o.hs), 32'(e.hs));
      chk({nm, "_vga_vs"}, 32'(o.vs), 32'(e.vs));
      chk({nm, "_blank_n"}, 32'(o.bn), 32'(e.bn));
      chk({nm, "_vga_clk"}, 32'(o.vc), 32'(e.vc));
   endtask

   task automatic step(input logic r);
      exp_t oa, ob;
      rst = r;
      @(posedge clk);
      n = r ? 0 : n + 1;
      @(negedge clk);
      oa = '{a_req, a_x, a_y, a_fs, a_r, a_g, a_b, a_hs, a_vs, a_bn, a_vc};
      ob = '{b_req, b_x, b_y, b_fs, b_r, b_g, b_b, b_hs, b_vs, b_bn, b_vc};
      check_inst("a", oa, model(n, 3, 8, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1'b0));
      check_inst("b", ob, model(n, 2, 16, 2, 3, 2, 6, 1, 2, 2, 1'b1, 1'b1));
   endtask

   initial begin
      int fs_a;
      int cnt;
      for (int i = 0; i < 256; i++) col_tbl[i] = 10'($urandom);

      // Reset held, then two full frames of the small raster.
      step(1'b1);
      step(1'b1);
      fs_a = 0;
      for (int i = 0; i < 2 * 252 + 20; i++) begin
         step(1'b0);
         if (a_fs) fs_a++;
      end
      chk("a_frame_count", 32'(fs_a), 32'd2);

      // Random run with occasional reset pulses of one or two clocks.
      for (int i = 0; i < 5000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            step(1'b1);
            if ($urandom_range(0, 1) == 1) step(1'b1);
         end else begin
            step(1'b0);
         end
      end

      // One-clock reset partway down a frame; next frame_start must be a full frame later.
      step(1'b1);
      for (int i = 0; i < 80; i++) step(1'b0);
      step(1'b1);
      cnt = 0;
      while (!a_fs && cnt < 1000) begin
         step(1'b0);
         cnt++;
      end
      chk("a_fs_after_rst", 32'(cnt), 32'd252);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
